cordic_vectoring: RTL and testbench

CORDIC_VECTORING -- requirements
Module: cordic_vectoring

---
 rtl/cordic_pkg.sv | 43 ++++
 rtl/cordic_vectoring_if.sv | 25 ++
 rtl/cordic_vector_stage.sv | 31 +++
 rtl/cordic_vectoring.sv | 120 ++++++++++++
 tb/tb_cordic_vectoring.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and arctangent table for the CORDIC vectoring block.
package cordic_pkg;

  localparam int CORDIC_IO_W  = 16;  // Q7.8 I/O, MSB reserved
  localparam int CORDIC_WW    = 32;  // Q15.16 internal datapath
  localparam int CORDIC_ITERS = 6;   // micro-rotations

  // Product of cos(atan(2^-i)) over 6 iterations, Q0.16
  localparam logic [15:0] CORDIC_KGAIN = 16'h9B7B;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_SCALE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // atan(2^-i) in degrees, Q15.16, rounded to nearest
  function automatic logic [31:0] cordic_atan(input int unsigned idx);
    logic [31:0] r;
    case (idx)
      0:       r = 32'h002D_0000;
      1:       r = 32'h001A_90A7;
      2:       r = 32'h000E_0947;
      3:       r = 32'h0007_2001;
      4:       r = 32'h0003_938B;
      5:       r = 32'h0001_CA38;
      6:       r = 32'h0000_E52A;
      7:       r = 32'h0000_7297;
      8:       r = 32'h0000_394C;
      9:       r = 32'h0000_1CA6;
      10:      r = 32'h0000_0E53;
      11:      r = 32'h0000_0729;
      12:      r = 32'h0000_0395;
      13:      r = 32'h0000_01CA;
      14:      r = 32'h0000_00E5;
      15:      r = 32'h0000_0073;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cordic_vectoring_if.sv
// Operand/result handshake bundle for the CORDIC vectoring block.
interface cordic_vectoring_if #(
  parameter int IO_WIDTH = cordic_pkg::CORDIC_IO_W
);
  logic                in_valid;
  logic                in_ready;
  logic [IO_WIDTH-1:0] x_in;
  logic [IO_WIDTH-1:0] y_in;
  logic                out_valid;
  logic                out_ready;
  logic [IO_WIDTH-1:0] degree_out;
  logic [IO_WIDTH-1:0] mag_out;

  // Producer of operands / consumer of results
  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, degree_out, mag_out
  );

  // The CORDIC block itself
  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, degree_out, mag_out
  );
endinterface

// File: rtl/cordic_vector_stage.sv
// One vectoring micro-rotation: drives y toward zero, accumulating the angle in z.
module cordic_vector_stage #(
  parameter int W   = 32,
  parameter int SHW = 3
) (
  input  logic signed [W-1:0]   x_i,
  input  logic signed [W-1:0]   y_i,
  input  logic signed [W-1:0]   z_i,
  input  logic        [SHW-1:0] shift_i,
  input  logic signed [W-1:0]   atan_i,
  output logic signed [W-1:0]   x_o,
  output logic signed [W-1:0]   y_o,
  output logic signed [W-1:0]   z_o
);
  logic signed [W-1:0] xs, ys;

  // Rotate by -/+ atan(2^-i) depending on the sign of y; both updates use pre-rotation values
  always_comb begin
    xs = x_i >>> shift_i;
    ys = y_i >>> shift_i;
    if (!y_i[W-1]) begin
      x_o = x_i + ys;
      y_o = y_i - xs;
      z_o = z_i + atan_i;
    end else begin
      x_o = x_i - ys;
      y_o = y_i + xs;
      z_o = z_i - atan_i;
    end
  end
endmodule

// File: rtl/cordic_vectoring.sv
// Iterative CORDIC vectoring: one micro-rotation per cycle, then gain correction.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int ITERATION_NUMBER     = CORDIC_ITERS,
  parameter int IO_WIDTH             = CORDIC_IO_W,
  parameter int ITERATION_WORD_WIDTH = CORDIC_WW
) (
  input logic              clk,
  input logic              reset,
  cordic_vectoring_if.slave io
);
  localparam int IOW = IO_WIDTH;
  localparam int WW  = ITERATION_WORD_WIDTH;
  localparam int CW  = $clog2(ITERATION_NUMBER + 1);

  localparam logic signed [WW-1:0] DEG90   = WW'(90 * 65536);
  localparam logic signed [WW-1:0] MAG_SAT = WW'(128 * 65536);
  localparam logic [IOW-1:0] DEG_OUT_MAX   = IOW'(90 * 256);
  localparam logic [IOW-1:0] LOW_MASK      = {1'b0, {(IOW-1){1'b1}}};

  state_t              state_q, state_d;
  logic [CW-1:0]       i_q, i_d;
  logic signed [WW-1:0] x_q, x_d, y_q, y_d, z_q, z_d, mag_q, mag_d;
  logic                zero_q, zero_d;

  logic signed [WW-1:0] x_nx, y_nx, z_nx, atan_i;
  logic signed [WW+16:0] prod;
  logic [IOW-1:0]      xm, ym, deg, mag;
  logic                accept;

  assign io.in_ready  = (state_q == S_IDLE) || (state_q == S_DONE && io.out_ready);
  assign io.out_valid = (state_q == S_DONE);
  assign accept       = io.in_valid && io.in_ready;

  // Reserved MSB of each operand is forced to zero
  assign xm = io.x_in & LOW_MASK;
  assign ym = io.y_in & LOW_MASK;

  assign atan_i = $signed(WW'(cordic_atan(32'(i_q))));
  assign prod   = x_q * $signed({1'b0, CORDIC_KGAIN});

  cordic_vector_stage #(.W(WW), .SHW(CW)) u_stage (
    .x_i(x_q), .y_i(y_q), .z_i(z_q), .shift_i(i_q), .atan_i(atan_i),
    .x_o(x_nx), .y_o(y_nx), .z_o(z_nx)
  );

  // Next-state: iterate, scale once, then hold the result until it is taken
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    mag_d   = mag_q;
    zero_d  = zero_q;
    case (state_q)
      S_ITER: begin
        x_d = x_nx;
        y_d = y_nx;
        z_d = z_nx;
        i_d = i_q + CW'(1);
        if (i_q == CW'(ITERATION_NUMBER - 1)) state_d = S_SCALE;
      end
      S_SCALE: begin
        mag_d   = WW'(prod >>> 16);
        state_d = S_DONE;
      end
      S_DONE:  if (io.out_ready) state_d = S_IDLE;
      default: ;
    endcase
    // Accept is only possible from IDLE or from DONE while the result is consumed
    if (accept) begin
      state_d = S_ITER;
      i_d     = '0;
      x_d     = $signed(WW'(xm) << 8);
      y_d     = $signed(WW'(ym) << 8);
      z_d     = '0;
      zero_d  = (xm == '0) && (ym == '0);
    end
  end

  // State, counter and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mag_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      mag_q   <= mag_d;
      zero_q  <= zero_d;
    end
  end

  // Angle clamped to 0..90 deg; a zero vector has no angle and reports 0
  always_comb begin
    deg = z_q[IOW+7:8];
    if (zero_q || z_q[WW-1]) deg = '0;
    else if (z_q > DEG90)    deg = DEG_OUT_MAX;
  end

  // Magnitude saturates at the largest Q7.8 value
  always_comb begin
    mag = mag_q[IOW+7:8];
    if (mag_q[WW-1])          mag = '0;
    else if (mag_q >= MAG_SAT) mag = LOW_MASK;
  end

  assign io.degree_out = deg;
  assign io.mag_out    = mag;
endmodule

// File: tb/tb_cordic_vectoring.sv
// Scoreboard bench for cordic_vectoring: directed operands with hand-derived result windows.
module tb_cordic_vectoring;
  typedef struct {
    int dlo; int dhi; int mlo; int mhi; int acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];

  cordic_vectoring_if bus();

  cordic_vectoring dut (.clk(clk), .reset(reset), .io(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act >= lo && act <= hi) passes++;
    else $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
  endtask

  // Present an operand, wait (bounded) for in_ready, and book the expected result
  task automatic send(input logic [15:0] x, input logic [15:0] y,
                      input int dlo, input int dhi, input int mlo, input int mhi,
                      output int waited);
    exp_t e;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.x_in = x;
    bus.y_in = y;
    #1;
    while (!bus.in_ready && waited < 40) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 0, 1, 1);
      bus.in_valid = 1'b0;
      return;
    end
    e = '{dlo, dhi, mlo, mhi, cyc};
    sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0, 0);
  endtask

  // Monitor: compare each consumed result against the oldest booked expectation
  initial begin : monitor
    int   first = -1;
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (!reset) first = -1;
      else if (bus.out_valid) begin
        if (first < 0) first = cyc;
        if (bus.out_ready) begin
          if (sb.size() == 0) chk("unexpected_result", 1, 0, 0);
          else begin
            e = sb.pop_front();
            chk("degree", int'(bus.degree_out), e.dlo, e.dhi);
            chk("mag", int'(bus.mag_out), e.mlo, e.mhi);
            chk("latency", first - e.acc_cyc, 8, 8);
          end
          first = -1;
        end
      end else first = -1;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks", checks);
    $fatal(1);
  end

  initial begin : stim
    int w;
    int d0, m0, nov;
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.out_ready = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0, 0);
    chk("rst_in_ready", int'(bus.in_ready), 1, 1);
    chk("rst_degree", int'(bus.degree_out), 0, 0);
    chk("rst_mag", int'(bus.mag_out), 0, 0);
    @(negedge clk);
    reset = 1'b1;

    // Back-to-back operands; in_valid stays high while busy with the next operand
    send(16'h0300, 16'h0300, 11059, 11981, 1063, 1109, w);
    send(16'h0100, 16'h0000, 0, 461, 250, 262, w);
    send(16'h0000, 16'h0200, 22579, 23040, 501, 523, w);
    send(16'h7F00, 16'h7F00, 11059, 11981, 32767, 32767, w);
    send(16'h0000, 16'h0000, 0, 0, 0, 0, w);
    send(16'h0400, 16'h0300, 8977, 9900, 1253, 1307, w);
    send(16'h8300, 16'h8300, 11059, 11981, 1063, 1109, w);
    send(16'h0200, 16'h0200, 11059, 11981, 708, 740, w);
    send(16'h0000, 16'h0100, 22579, 23040, 250, 262, w);
    drain();

    // Consumer stall: result must hold and no new operand may enter
    bus.out_ready = 1'b0;
    send(16'h0300, 16'h0300, 11059, 11981, 1063, 1109, w);
    w = 0;
    while (!bus.out_valid && w < 20) begin
      @(negedge clk); #1;
      w++;
    end
    chk("stall_out_valid", int'(bus.out_valid), 1, 1);
    d0 = int'(bus.degree_out);
    m0 = int'(bus.mag_out);
    bus.in_valid = 1'b1;
    bus.x_in = 16'h0100;
    bus.y_in = 16'h0000;
    repeat (5) begin
      @(negedge clk); #1;
      chk("stall_valid", int'(bus.out_valid), 1, 1);
      chk("stall_in_ready", int'(bus.in_ready), 0, 0);
      chk("stall_degree", int'(bus.degree_out), d0, d0);
      chk("stall_mag", int'(bus.mag_out), m0, m0);
    end
    bus.out_ready = 1'b1;
    send(16'h0100, 16'h0000, 0, 461, 250, 262, w);
    chk("same_edge_accept", w, 0, 0);
    drain();

    // Reset in the third ITER cycle discards the operation
    send(16'h0300, 16'h0300, 11059, 11981, 1063, 1109, w);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0, 0);
    chk("midrst_degree", int'(bus.degree_out), 0, 0);
    chk("midrst_mag", int'(bus.mag_out), 0, 0);
    chk("midrst_in_ready", int'(bus.in_ready), 1, 1);
    @(negedge clk);
    reset = 1'b1;
    nov = 0;
    repeat (12) begin
      @(negedge clk); #1;
      if (bus.out_valid) nov++;
    end
    chk("no_valid_after_reset", nov, 0, 0);
    send(16'h0400, 16'h0300, 8977, 9900, 1253, 1307, w);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
